uart_rx: RTL

Asynchronous serial receiver, the receive-side counterpart of `uart_tx` on the same 8N1 link. It samples `rx_in` and detects the start-bit edge. Each bit is sampled at its nominal centre using a clock-derived baud counter. Each good frame is presented as a byte with a one-cycle `rx_done` strobe, and a bad stop bit is flagged with `frame_err`. It shares the `CLK_FREQ`/`BAUD_RATE` parameterisation of `uart_tx`, so a TX/RX pair configured identically interoperates directly.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Groups the serial line and the receive-side result signals of uart_rx.
//   rx_in     : serial line, idle high (driven by the line/master side)
//   data_rx   : last correctly received byte
//   rx_done   : one-cycle strobe, data_rx just updated
//   frame_err : one-cycle strobe, stop bit sampled low
//   rx_busy   : receiver is inside a frame (FSM not idle)
// Modports: master = line driver / consumer, slave = receiver.
// ---------------------------------------------------------------------------
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] data_rx;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_in,
    input  data_rx,
    input  rx_done,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_in,
    output data_rx,
    output rx_done,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver. The line is synchronised through two
// flops, the start edge is qualified at half a bit, and every following bit
// is sampled at its nominal centre using a clock-derived baud counter.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_if.slave (rx_in in; data_rx, rx_done, frame_err,
//          rx_busy out, all outputs registered)
// Parameters:
//   CLK_FREQ  : clock frequency in Hz
//   BAUD_RATE : line rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [2:0]       bit_idx_r, bit_idx_nx;
  logic [7:0]       shift_r, shift_nx;
  logic [7:0]       data_r, data_nx;
  logic             done_r, done_nx;
  logic             ferr_r, ferr_nx;
  logic             busy_r, busy_nx;
  logic             sync1_r, sync2_r;
  logic             rx_sync_s;

  // Two-flop synchroniser; both flops reset high so leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.rx_in;
      sync2_r <= sync1_r;
    end
  end

  assign rx_sync_s = sync2_r;

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      done_r    <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      bit_idx_r <= bit_idx_nx;
      shift_r   <= shift_nx;
      data_r    <= data_nx;
      done_r    <= done_nx;
      ferr_r    <= ferr_nx;
      busy_r    <= busy_nx;
    end
  end

  // Next-state, counter, shift register and strobe logic.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    bit_idx_nx = bit_idx_r;
    shift_nx   = shift_r;
    data_nx    = data_r;
    done_nx    = 1'b0;
    ferr_nx    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_nx     = CNT_ZERO;
        bit_idx_nx = 3'd0;
        if (!rx_sync_s) begin
          state_nx = ST_START;
        end else begin
          state_nx = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx = CNT_ZERO;
          // Line high again at mid start bit: a glitch, drop it silently.
          if (!rx_sync_s) begin
            state_nx = ST_DATA;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nx     = CNT_ZERO;
          // LSB arrives first, so shift right and insert at the MSB.
          shift_nx   = {rx_sync_s, shift_r[7:1]};
          bit_idx_nx = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_nx = ST_STOP;
          end else begin
            state_nx = ST_DATA;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_r == LAST_CNT) begin
          cnt_nx = CNT_ZERO;
          // Returning to idle at mid stop bit leaves half a bit of margin
          // to catch a back-to-back start edge.
          if (rx_sync_s) begin
            data_nx  = shift_r;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = ST_BREAK;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end

      ST_BREAK: begin
        // A held-low line must go high before a new frame is accepted.
        cnt_nx = CNT_ZERO;
        if (rx_sync_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_BREAK;
        end
      end

      default: begin
        state_nx   = ST_IDLE;
        cnt_nx     = CNT_ZERO;
        bit_idx_nx = 3'd0;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  assign bus.data_rx   = data_r;
  assign bus.rx_done   = done_r;
  assign bus.frame_err = ferr_r;
  assign bus.rx_busy   = busy_r;

endmodule
